// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source selects and load funct3 codes.
// Pure definitions, no logic.
// Imported by wb_stage and load_extract.
package wb_pkg;

  // Result source select (in_wb_sel); 101-111 fall back to zero
  localparam logic [2:0] WB_ZERO = 3'b000;
  localparam logic [2:0] WB_ALU  = 3'b001;
  localparam logic [2:0] WB_MEM  = 3'b010;
  localparam logic [2:0] WB_PC   = 3'b011;
  localparam logic [2:0] WB_CSR  = 3'b100;

  // Load type (funct3); 111 is not a valid load
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Load data extraction: picks the addressed byte/half/word lane and sign/zero extends it.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [2:0]      off;
  logic [XLEN-1:0] shifted;

  // Byte offset within the word; a 32-bit datapath only has four lanes
  always_comb begin
    off = (XLEN == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
  end

  // Bring the addressed lane down to bit 0
  always_comb begin
    shifted = word >> {off, 3'b000};
  end

  // Extend per load type; misaligned or illegal loads yield zero data
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    unique case (funct3)
      F3_LB:  data = XLEN'($signed(shifted[7:0]));
      F3_LBU: data = XLEN'(shifted[7:0]);
      F3_LH: begin
        misalign = off[0];
        data     = XLEN'($signed(shifted[15:0]));
      end
      F3_LHU: begin
        misalign = off[0];
        data     = XLEN'(shifted[15:0]);
      end
      F3_LW: begin
        misalign = (off[1:0] != 2'b00);
        data     = XLEN'($signed(shifted[31:0]));
      end
      F3_LWU: begin
        // Unsigned word load only exists on RV64
        misalign = (XLEN == 32) || (off[1:0] != 2'b00);
        data     = XLEN'(shifted[31:0]);
      end
      F3_LD: begin
        // Doubleword load only exists on RV64; passes the raw word through
        misalign = (XLEN == 32) || (off != 3'b000);
        data     = word;
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) data = '0;
  end

endmodule

// File: rtl/wb_stage.sv
// Registered RV64 writeback stage: source select, load extract, retire counter.
// Latency: 1 cycle from capture to outputs.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_we,
  input  logic [2:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [2:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_mem,
  input  logic [XLEN-1:0]  in_csr,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_we,
  output logic [RA_W-1:0]  out_rd,
  output logic [XLEN-1:0]  out_data,
  output logic             out_misalign,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [XLEN-1:0] ld_data;
  logic            ld_misalign;
  logic [XLEN-1:0] sel_data;
  logic            nxt_misalign;
  logic            nxt_we;
  logic [XLEN-1:0] nxt_data;
  logic            fire;
  logic            capture;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .word     (in_mem),
    .funct3   (in_funct3),
    .addr_lo  (in_addr_lo),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  // Handshake: accept when empty or when the held entry leaves this cycle
  always_comb begin
    in_ready = !out_valid || out_ready;
    fire     = out_valid && out_ready;
    capture  = in_valid && in_ready && !flush;
  end

  // Result source mux; load misalign only matters when the load path is selected
  always_comb begin
    sel_data     = '0;
    nxt_misalign = 1'b0;
    case (in_wb_sel)
      WB_ALU: sel_data = in_alu;
      WB_MEM: begin
        sel_data     = ld_data;
        nxt_misalign = ld_misalign;
      end
      WB_PC:   sel_data = in_pc_plus4;
      WB_CSR:  sel_data = in_csr;
      default: sel_data = '0;
    endcase
  end

  // x0 is never written and never forwards a non-zero value
  always_comb begin
    nxt_we   = in_we && (in_rd != '0) && !nxt_misalign;
    nxt_data = (nxt_misalign || (in_rd == '0)) ? '0 : sel_data;
  end

  // Output register: flush drops the incoming entry, capture loads, lone fire empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_we       <= 1'b0;
      out_rd       <= '0;
      out_data     <= '0;
      out_misalign <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_we       <= nxt_we;
      out_rd       <= in_rd;
      out_data     <= nxt_data;
      out_misalign <= nxt_misalign;
    end else if (fire) begin
      out_valid    <= 1'b0;
    end
  end

  // Retire counter: every fired entry counts, flushed cycle or not, misaligned or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (fire) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, source select, load extract, stall, flush, wrap.
// Inputs are driven 1 time unit after the rising edge; outputs are checked there too.
// A 4-bit retire counter keeps the wrap case short.
module tb_wb_stage;

  localparam int XLEN  = 64;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [RA_W-1:0]  in_rd;
  logic             in_we;
  logic [2:0]       in_wb_sel;
  logic [2:0]       in_funct3;
  logic [2:0]       in_addr_lo;
  logic [XLEN-1:0]  in_pc_plus4;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_mem;
  logic [XLEN-1:0]  in_csr;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic             out_we;
  logic [RA_W-1:0]  out_rd;
  logic [XLEN-1:0]  out_data;
  logic             out_misalign;
  logic [CNT_W-1:0] retire_cnt;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_cnt = 4'd0;

  wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_we        (in_we),
    .in_wb_sel    (in_wb_sel),
    .in_funct3    (in_funct3),
    .in_addr_lo   (in_addr_lo),
    .in_pc_plus4  (in_pc_plus4),
    .in_alu       (in_alu),
    .in_mem       (in_mem),
    .in_csr       (in_csr),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_we       (out_we),
    .out_rd       (out_rd),
    .out_data     (out_data),
    .out_misalign (out_misalign),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [4:0] rd, input logic we, input logic [2:0] sel,
                           input logic [63:0] val);
    in_rd       = rd;
    in_we       = we;
    in_wb_sel   = sel;
    in_alu      = val;
    in_pc_plus4 = val;
    in_csr      = val;
  endtask

  task automatic test_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (out_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", out_we); end
    vectors++; if (out_rd !== 5'd0) begin miscompares++; $display("FAIL reset_rd got %0d want 0", out_rd); end
    vectors++; if (out_data !== 64'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", out_data); end
    vectors++; if (out_misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %b want 0", out_misalign); end
    vectors++; if (retire_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_alu();
    out_ready = 1'b1;
    set_entry(5'd5, 1'b1, 3'b001, 64'h1234);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL alu_valid got %b want 1", out_valid); end
    vectors++; if (out_we !== 1'b1) begin miscompares++; $display("FAIL alu_we got %b want 1", out_we); end
    vectors++; if (out_rd !== 5'd5) begin miscompares++; $display("FAIL alu_rd got %0d want 5", out_rd); end
    vectors++; if (out_data !== 64'h1234) begin miscompares++; $display("FAIL alu_data got %h want 1234", out_data); end
    vectors++; if (retire_cnt !== 4'd0) begin miscompares++; $display("FAIL alu_cnt_before got %0d want 0", retire_cnt); end
    tick();
    exp_cnt++;
    vectors++; if (retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL alu_cnt_after got %0d want %0d", retire_cnt, exp_cnt); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL alu_drain got %b want 0", out_valid); end
  endtask

  task automatic test_select();
    logic [2:0]  sels [4] = '{3'b100, 3'b000, 3'b101, 3'b111};
    logic [63:0] exps [4] = '{64'h5555, 64'h0, 64'h0, 64'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_entry(5'd9, 1'b1, sels[i], 64'h5555);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (out_data !== exps[i]) begin
        miscompares++; $display("FAIL sel_%0d_data got %h want %h", i, out_data, exps[i]);
      end
      tick();
      exp_cnt++;
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3   [11] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110,
                               3'b011, 3'b010, 3'b001, 3'b011, 3'b111};
    logic [2:0]  al   [11] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd0, 3'd2, 3'd1, 3'd4, 3'd0};
    logic [63:0] mem  [11] = '{64'h00000000_80FF0000, 64'h00000000_80FF0000,
                               64'h00000000_80FF0000, 64'h00000000_80FF0000,
                               64'h80000001_00000000, 64'h80000001_00000000,
                               64'h01234567_89ABCDEF, 64'h00000000_80FF0000,
                               64'h00000000_80FF0000, 64'h01234567_89ABCDEF,
                               64'h01234567_89ABCDEF};
    logic [63:0] exd  [11] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_000000FF,
                               64'hFFFFFFFF_FFFF80FF, 64'h00000000_000080FF,
                               64'hFFFFFFFF_80000001, 64'h00000000_80000001,
                               64'h01234567_89ABCDEF, 64'h0, 64'h0, 64'h0, 64'h0};
    logic        exm  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_entry(5'd3, 1'b1, 3'b010, 64'h0);
      in_mem     = mem[i];
      in_funct3  = f3[i];
      in_addr_lo = al[i];
      in_valid   = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (out_data !== exd[i]) begin
        miscompares++; $display("FAIL load_%0d_data got %h want %h", i, out_data, exd[i]);
      end
      vectors++;
      if (out_misalign !== exm[i]) begin
        miscompares++; $display("FAIL load_%0d_misalign got %b want %b", i, out_misalign, exm[i]);
      end
      vectors++;
      if (out_we !== !exm[i]) begin
        miscompares++; $display("FAIL load_%0d_we got %b want %b", i, out_we, !exm[i]);
      end
      tick();
      exp_cnt++;
      vectors++;
      if (retire_cnt !== exp_cnt) begin
        miscompares++; $display("FAIL load_%0d_cnt got %0d want %0d", i, retire_cnt, exp_cnt);
      end
    end
    in_funct3  = 3'b000;
    in_addr_lo = 3'd0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_entry(5'd1, 1'b1, 3'b001, 64'hAAAA);
    in_valid = 1'b1;
    tick();
    set_entry(5'd2, 1'b1, 3'b001, 64'hBBBB);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_%0d_in_ready got %b want 0", i, in_ready); end
      vectors++; if (out_data !== 64'hAAAA || out_rd !== 5'd1 || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall_%0d_hold got %h/%0d/%b want aaaa/1/1", i, out_data, out_rd, out_valid);
      end
      vectors++; if (retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL stall_%0d_cnt got %0d want %0d", i, retire_cnt, exp_cnt); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    vectors++; if (out_data !== 64'hBBBB || out_rd !== 5'd2 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_next got %h/%0d/%b want bbbb/2/1", out_data, out_rd, out_valid);
    end
    vectors++; if (retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL b2b_cnt got %0d want %0d", retire_cnt, exp_cnt); end
    tick();
    exp_cnt++;
    vectors++; if (out_valid !== 1'b0 || retire_cnt !== exp_cnt) begin
      miscompares++; $display("FAIL b2b_drain got %b/%0d want 0/%0d", out_valid, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_entry(5'd4, 1'b1, 3'b001, 64'hCCCC);
    in_valid = 1'b1;
    tick();
    set_entry(5'd6, 1'b1, 3'b001, 64'hDDDD);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    exp_cnt++;
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", out_valid); end
    vectors++; if (retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL flush_cnt got %0d want %0d", retire_cnt, exp_cnt); end
    tick();
    vectors++; if (out_valid !== 1'b0 || out_data === 64'hDDDD) begin
      miscompares++; $display("FAIL flush_dropped got %b/%h want 0/not dddd", out_valid, out_data);
    end
  endtask

  task automatic test_rd_zero_wrap();
    out_ready = 1'b1;
    set_entry(5'd8, 1'b1, 3'b001, 64'h77);
    for (int i = 0; i < 20 && exp_cnt != 4'hF; i++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      exp_cnt++;
    end
    vectors++; if (retire_cnt !== 4'hF) begin miscompares++; $display("FAIL wrap_pre_cnt got %0d want 15", retire_cnt); end
    set_entry(5'd0, 1'b1, 3'b011, 64'h80000004);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_we !== 1'b0) begin
      miscompares++; $display("FAIL rd0_we got %b/%b want 1/0", out_valid, out_we);
    end
    vectors++; if (out_data !== 64'd0) begin miscompares++; $display("FAIL rd0_data got %h want 0", out_data); end
    tick();
    exp_cnt++;
    vectors++; if (retire_cnt !== 4'd0) begin miscompares++; $display("FAIL wrap_cnt got %0d want 0", retire_cnt); end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    set_entry(5'd11, 1'b1, 3'b001, 64'h99);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL pre_reset_cnt got %0d want %0d", retire_cnt, exp_cnt); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_data !== 64'd0 || retire_cnt !== 4'd0) begin
      miscompares++; $display("FAIL async_reset got %b/%h/%0d want 0/0/0", out_valid, out_data, retire_cnt);
    end
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    vectors++; if (retire_cnt !== 4'd0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL lost_entry got %0d/%b want 0/0", retire_cnt, out_valid);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    in_mem      = '0;
    in_funct3   = 3'b000;
    in_addr_lo  = 3'd0;
    set_entry(5'd0, 1'b0, 3'b000, 64'h0);
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_alu();
    test_select();
    test_load();
    test_back_to_back();
    test_flush();
    test_rd_zero_wrap();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
